// File: rtl/keypad_scan_entry.sv
// 4x4 keypad column scanner with debounced press/release and
// two-operand entry registers that alternate on each accepted key.
module keypad_scan_entry #(
  parameter int SCAN_DIV     = 5000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk_main,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] num_1,
  output logic [3:0] num_2,
  output logic       sel
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_e;

  state_e st_q, st_d;

  logic [3:0]    sync1_q, sync2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] match_q, match_d;
  logic [CW-1:0] rel_q, rel_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    num_1_q, num_1_d;
  logic [3:0]    num_2_q, num_2_d;
  logic          sel_q, sel_d;

  logic       tick;
  logic       any_low;
  logic [1:0] low_row;
  logic [3:0] code;

  assign tick    = (div_q == DIV_LAST);
  assign any_low = ~&sync2_q;
  assign code    = {row_q, col_q};
  assign div_d   = tick ? '0 : div_q + 1'b1;

  // Lowest-index low row wins when several rows are pulled down.
  always_comb begin
    low_row = 2'd0;
    if (!sync2_q[0])      low_row = 2'd0;
    else if (!sync2_q[1]) low_row = 2'd1;
    else if (!sync2_q[2]) low_row = 2'd2;
    else if (!sync2_q[3]) low_row = 2'd3;
  end

  always_comb begin
    st_d        = st_q;
    col_d       = col_q;
    row_d       = row_q;
    match_d     = match_q;
    rel_d       = rel_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    num_1_d     = num_1_q;
    num_2_d     = num_2_q;
    sel_d       = sel_q;
    if (tick) begin
      unique case (st_q)
        SCAN: begin
          if (any_low) begin
            row_d   = low_row;
            match_d = CNT_ONE;
            st_d    = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (any_low && low_row == row_q) begin
            if (match_q + CNT_ONE == CNT_MAX) begin
              match_d     = CNT_MAX;
              st_d        = HELD;
              key_code_d  = code;
              key_valid_d = 1'b1;
              sel_d       = ~sel_q;
              if (!sel_q) num_1_d = code;
              else        num_2_d = code;
            end else begin
              match_d = match_q + CNT_ONE;
            end
          end else begin
            match_d = '0;
            col_d   = col_q + 2'd1;
            st_d    = SCAN;
          end
        end
        HELD: begin
          if (!any_low) begin
            rel_d = CNT_ONE;
            st_d  = RELEASE;
          end
        end
        RELEASE: begin
          if (any_low) begin
            rel_d = '0;
            st_d  = HELD;
          end else if (rel_q + CNT_ONE == CNT_MAX) begin
            rel_d   = '0;
            match_d = '0;
            col_d   = col_q + 2'd1;
            st_d    = SCAN;
          end else begin
            rel_d = rel_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      div_q       <= '0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      match_q     <= '0;
      rel_q       <= '0;
      st_q        <= SCAN;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      num_1_q     <= 4'd0;
      num_2_q     <= 4'd0;
      sel_q       <= 1'b0;
    end else begin
      sync1_q     <= row_in;
      sync2_q     <= sync1_q;
      div_q       <= div_d;
      col_q       <= col_d;
      row_q       <= row_d;
      match_q     <= match_d;
      rel_q       <= rel_d;
      st_q        <= st_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      num_1_q     <= num_1_d;
      num_2_q     <= num_2_d;
      sel_q       <= sel_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign num_1     = num_1_q;
  assign num_2     = num_2_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Bench for keypad_scan_entry: physical keypad matrix model plus an
// expected-key queue and operand model checked on every key_valid.
module tb_keypad_scan_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] num_1, num_2;
  logic       sel;

  keypad_scan_entry #(
    .SCAN_DIV(4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk_main (clk),
    .reset    (reset),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .num_1    (num_1),
    .num_2    (num_2),
    .sel      (sel)
  );

  always #5 clk = ~clk;

  logic [3:0] keys [4];
  int n_err = 0;
  int n_chk = 0;

  // A pressed switch shorts its row to the column being driven low.
  always_comb begin
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(keys[r] & ~col_out);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [3:0] exp_q [$];
  logic [3:0] m_n1, m_n2, e;
  logic       m_sel;

  always @(negedge clk) begin
    if (reset) begin
      m_n1  = 4'd0;
      m_n2  = 4'd0;
      m_sel = 1'b0;
    end else begin
      check("col_onehot", 32'($countones(~col_out)), 32'd1);
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_kv", 32'(key_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (!m_sel) m_n1 = e;
          else        m_n2 = e;
          m_sel = ~m_sel;
          check("key_code", 32'(key_code), 32'(e));
          check("num_1", 32'(num_1), 32'(m_n1));
          check("num_2", 32'(num_2), 32'(m_n2));
          check("sel", 32'(sel), 32'(m_sel));
        end
      end
    end
  end

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) keys[r] = 4'd0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Hold a key long enough to be found and debounced, then release it.
  task automatic long_press(input int r, input int c, input int r2);
    @(posedge clk);
    #1;
    keys[r][c] = 1'b1;
    if (r2 >= 0) keys[r2][c] = 1'b1;
    exp_q.push_back(4'(r * 4 + c));
    repeat (50) @(posedge clk);
    #1 clear_keys();
    repeat (40) @(posedge clk);
    check("accepted", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int r, c, r2, g;
    clear_keys();
    do_reset();
    @(negedge clk);
    check("rst_col", 32'(col_out), 32'hE);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_kv", 32'(key_valid), 32'd0);
    check("rst_n1", 32'(num_1), 32'd0);
    check("rst_n2", 32'(num_2), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      check("idle_col", 32'(col_out),
            32'(~(4'b0001 << ((k / 4) % 4)) & 4'hF));
    end

    long_press(2, 1, -1);
    check("n1_9", 32'(num_1), 32'h9);
    check("sel_1", 32'(sel), 32'd1);
    long_press(3, 3, -1);
    check("n2_f", 32'(num_2), 32'hF);
    check("n1_keep", 32'(num_1), 32'h9);
    check("sel_0", 32'(sel), 32'd0);
    long_press(1, 0, 3);
    check("code_4", 32'(key_code), 32'h4);

    for (int i = 0; i < 14; i++) begin
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        @(posedge clk);
        #1 keys[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 clear_keys();
        repeat (8) @(posedge clk);
      end
      r  = $urandom_range(0, 3);
      c  = $urandom_range(0, 3);
      r2 = (r < 3 && $urandom_range(0, 1) == 1) ? $urandom_range(r + 1, 3) : -1;
      long_press(r, c, r2);
    end

    do_reset();
    @(posedge clk);
    #1 keys[2][1] = 1'b1;
    exp_q.push_back(4'h9);
    for (int w = 0; w < 80 && exp_q.size() != 0; w++) @(posedge clk);
    check("held_acc", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (6) @(posedge clk);
    check("held_n1", 32'(num_1), 32'h9);
    #1;
    reset = 1'b1;
    clear_keys();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rr_n1", 32'(num_1), 32'd0);
    check("rr_sel", 32'(sel), 32'd0);
    check("rr_col", 32'(col_out), 32'hE);
    check("rr_kv", 32'(key_valid), 32'd0);
    repeat (40) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
